// File: rtl/ifid_pipe_reg.sv
// Elastic IF/ID pipeline register: STAGES valid-tagged slots, ripple-ready handshake, flush, MIPS field decode.
// Optional performance counters (stall_cnt, flush_cnt) are compiled in with `define IFID_PERF_EN.
module ifid_pipe_reg #(
    parameter int                INST_W   = 32,
    parameter int                PC_W     = 32,
    parameter int                STAGES   = 2,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_npc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_npc,
    output logic [5:0]        out_op,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_funct,
    output logic [15:0]       out_imm16,
    output logic [25:0]       out_addr26
`ifdef IFID_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] r_valid;
    logic [INST_W-1:0] r_inst [STAGES];
    logic [PC_W-1:0]   r_npc  [STAGES];

    logic [STAGES:0]   w_room;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_mv;
    logic              w_accept;
    logic [INST_W-1:0] w_src_inst [STAGES];
    logic [PC_W-1:0]   w_src_npc  [STAGES];

    // Ready ripples from the output side: w_room[k] means slot k can take a new entry this cycle.
    always_comb begin
        w_room = '0;
        w_adv  = '0;
        w_room[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_adv[k]  = r_valid[k] && w_room[k+1];
            w_room[k] = !r_valid[k] || w_adv[k];
        end
    end

    assign in_ready = !flush && w_room[0];
    assign w_accept = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot_src
            if (gi == 0) begin : g_first
                assign w_mv[gi]       = w_accept;
                assign w_src_inst[gi] = in_inst;
                assign w_src_npc[gi]  = in_npc;
            end else begin : g_chain
                assign w_mv[gi]       = w_adv[gi-1];
                assign w_src_inst[gi] = r_inst[gi-1];
                assign w_src_npc[gi]  = r_npc[gi-1];
            end
        end
    endgenerate

    // Data registers only change when a real entry moves in; bubbles just clear the valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_inst[k] <= NOP_INST;
                r_npc[k]  <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_inst[k] <= NOP_INST;
                r_npc[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_room[k]) begin
                    r_valid[k] <= w_mv[k];
                    if (w_mv[k]) begin
                        r_inst[k] <= w_src_inst[k];
                        r_npc[k]  <= w_src_npc[k];
                    end
                end
            end
        end
    end

    assign out_valid = r_valid[LAST];
    assign out_inst  = out_valid ? r_inst[LAST] : NOP_INST;
    assign out_npc   = out_valid ? r_npc[LAST]  : '0;

    assign out_op     = out_inst[31:26];
    assign out_rs     = out_inst[25:21];
    assign out_rt     = out_inst[20:16];
    assign out_rd     = out_inst[15:11];
    assign out_shamt  = out_inst[10:6];
    assign out_funct  = out_inst[5:0];
    assign out_imm16  = out_inst[15:0];
    assign out_addr26 = out_inst[25:0];

`ifdef IFID_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Bench for ifid_pipe_reg: STAGES=1,2,4 instances share stimulus and are checked against a FIFO-with-ready-time model.
module tb_ifid_pipe_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_npc = '0;

    always #5 clk = ~clk;

    logic [2:0]        w_ready, w_valid;
    logic [2:0][31:0]  w_inst, w_npc;
    logic [2:0][5:0]   w_op, w_funct;
    logic [2:0][4:0]   w_rs, w_rt, w_rd, w_shamt;
    logic [2:0][15:0]  w_imm;
    logic [2:0][25:0]  w_addr;
`ifdef IFID_PERF_EN
    logic [2:0][15:0]  w_stall, w_flush;
`endif

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            ifid_pipe_reg #(
                .INST_W  (32),
                .PC_W    (32),
                .STAGES  ((gi == 0) ? 1 : ((gi == 1) ? 2 : 4)),
                .NOP_INST(32'h0000_0000)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (w_ready[gi]),
                .in_inst   (in_inst),
                .in_npc    (in_npc),
                .flush     (flush),
                .out_valid (w_valid[gi]),
                .out_ready (out_ready),
                .out_inst  (w_inst[gi]),
                .out_npc   (w_npc[gi]),
                .out_op    (w_op[gi]),
                .out_rs    (w_rs[gi]),
                .out_rt    (w_rt[gi]),
                .out_rd    (w_rd[gi]),
                .out_shamt (w_shamt[gi]),
                .out_funct (w_funct[gi]),
                .out_imm16 (w_imm[gi]),
                .out_addr26(w_addr[gi])
`ifdef IFID_PERF_EN
                ,
                .stall_cnt (w_stall[gi]),
                .flush_cnt (w_flush[gi])
`endif
            );
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each instance is a FIFO of capacity S; an entry accepted at edge N may leave the
    // head position once edge N+S-1 has passed (it can never pass its predecessor).
    int          m_head [3];
    int          m_cnt  [3];
    int          m_rdy  [3][16];
    logic [31:0] m_inst [3][16];
    logic [31:0] m_npc  [3][16];
    int          m_stall[3];
    int          m_flush[3];
    int          cyc;

    function automatic int sv(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    function automatic logic mdl_valid(input int i);
        return (m_cnt[i] > 0) && (m_rdy[i][m_head[i]] <= cyc);
    endfunction

    function automatic logic mdl_ready(input int i);
        return !flush && ((m_cnt[i] < sv(i)) || (mdl_valid(i) && out_ready));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i]   <= 0;
                m_head[i]  <= 0;
                m_stall[i] <= 0;
                m_flush[i] <= 0;
            end
            cyc <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic v;
                logic ir;
                int   nc;
                int   nh;
                int   tail;
                v  = mdl_valid(i);
                ir = mdl_ready(i);
                nc = m_cnt[i];
                nh = m_head[i];
                if (v && out_ready && i == 1) begin
                    $display("xfer S2 inst=0x%08h npc=0x%08h", m_inst[i][nh], m_npc[i][nh]);
                end
                if (flush) begin
                    nc = 0;
                end else begin
                    if (v && out_ready) begin
                        nc = nc - 1;
                        nh = (nh + 1) % 16;
                    end
                    if (in_valid && ir) begin
                        tail = (m_head[i] + m_cnt[i]) % 16;
                        m_inst[i][tail] <= in_inst;
                        m_npc[i][tail]  <= in_npc;
                        m_rdy[i][tail]  <= cyc + sv(i);
                        nc = nc + 1;
                    end
                end
                m_cnt[i]  <= nc;
                m_head[i] <= nh;
                if (v && !out_ready && m_stall[i] < 65535) m_stall[i] <= m_stall[i] + 1;
                if (flush && m_flush[i] < 65535) m_flush[i] <= m_flush[i] + 1;
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                logic        ev;
                logic [31:0] ei;
                logic [31:0] en;
                ev = mdl_valid(i);
                ei = ev ? m_inst[i][m_head[i]] : 32'h0;
                en = ev ? m_npc[i][m_head[i]]  : 32'h0;
                chk($sformatf("S%0d_out_valid", sv(i)), 64'(w_valid[i]), 64'(ev));
                chk($sformatf("S%0d_out_inst", sv(i)), 64'(w_inst[i]), 64'(ei));
                chk($sformatf("S%0d_out_npc", sv(i)), 64'(w_npc[i]), 64'(en));
                chk($sformatf("S%0d_in_ready", sv(i)), 64'(w_ready[i]), 64'(mdl_ready(i)));
                chk($sformatf("S%0d_fields_a", sv(i)),
                    64'({w_op[i], w_rs[i], w_rt[i], w_rd[i], w_shamt[i], w_funct[i]}), 64'(ei));
                chk($sformatf("S%0d_fields_b", sv(i)),
                    64'({w_imm[i], w_addr[i]}), 64'({ei[15:0], ei[25:0]}));
`ifdef IFID_PERF_EN
                chk($sformatf("S%0d_stall_cnt", sv(i)), 64'(w_stall[i]), 64'(m_stall[i]));
                chk($sformatf("S%0d_flush_cnt", sv(i)), 64'(w_flush[i]), 64'(m_flush[i]));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int acc;
        logic seen;
        rst = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", 64'(w_valid[i]), 64'd0);
            chk("rst_out_inst", 64'(w_inst[i]), 64'd0);
            chk("rst_in_ready", 64'(w_ready[i]), 64'd1);
`ifdef IFID_PERF_EN
            chk("rst_stall_cnt", 64'(w_stall[i]), 64'd0);
            chk("rst_flush_cnt", 64'(w_flush[i]), 64'd0);
`endif
        end
        rst = 1'b0;

        // Two-instruction stream with out_ready held high; latency pinned per instance.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'h8C22_0004;
        in_npc    = 32'h4;
        step();
        in_inst = 32'h0085_1020;
        in_npc  = 32'h8;
        chk("lat_S2_not_yet", 64'(w_valid[1]), 64'd0);
        chk("lat_S1_inst", 64'(w_inst[0]), 64'h8C22_0004);
        step();
        in_valid = 1'b0;
        chk("stream_S2_valid", 64'(w_valid[1]), 64'd1);
        chk("stream_S2_op", 64'(w_op[1]), 64'h23);
        chk("stream_S2_rs", 64'(w_rs[1]), 64'd1);
        chk("stream_S2_rt", 64'(w_rt[1]), 64'd2);
        chk("stream_S2_imm16", 64'(w_imm[1]), 64'h0004);
        chk("lat_S4_not_yet", 64'(w_valid[2]), 64'd0);
        step();
        chk("stream_S2_funct", 64'(w_funct[1]), 64'h20);
        chk("stream_S2_rd", 64'(w_rd[1]), 64'd2);
        chk("stream_S2_npc", 64'(w_npc[1]), 64'h8);
        chk("lat_S4_still_not", 64'(w_valid[2]), 64'd0);
        step();
        chk("lat_S4_valid", 64'(w_valid[2]), 64'd1);
        chk("lat_S4_inst", 64'(w_inst[2]), 64'h8C22_0004);
        repeat (4) step();

        // Back-pressure: offer five entries with out_ready low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            in_inst = $urandom;
            in_npc  = $urandom;
            #1;
            if (w_ready[1]) acc++;
            step();
        end
        chk("bp_S2_accepted", 64'(acc), 64'd2);
        for (int i = 0; i < 3; i++) chk("bp_full_in_ready", 64'(w_ready[i]), 64'd0);

        // Flush a full pipe while an entry is offered.
        flush   = 1'b1;
        in_inst = 32'hDEAD_BEEF;
        #1;
        for (int i = 0; i < 3; i++) chk("flush_in_ready", 64'(w_ready[i]), 64'd0);
        step();
        flush   = 1'b0;
        in_inst = $urandom;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("post_flush_valid", 64'(w_valid[i]), 64'd0);
            chk("post_flush_inst", 64'(w_inst[i]), 64'd0);
            chk("post_flush_ready", 64'(w_ready[i]), 64'd1);
        end

        // Refill, then assert reset between edges.
        repeat (4) begin
            in_inst = $urandom;
            in_npc  = $urandom;
            step();
        end
        chk("refill_S2_valid", 64'(w_valid[1]), 64'd1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("async_rst_valid", 64'(w_valid[i]), 64'd0);
            chk("async_rst_inst", 64'(w_inst[i]), 64'd0);
            chk("async_rst_npc", 64'(w_npc[i]), 64'd0);
            chk("async_rst_ready", 64'(w_ready[i]), 64'd1);
        end
        step();
        rst = 1'b0;

        // Randomised traffic; the negedge compare does the checking.
        for (int k = 0; k < 3000; k++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = (k % 200 < 40) ? (($urandom % 5) == 0) : (($urandom % 3) != 0);
            flush     = ($urandom % 25) == 0;
            in_inst   = $urandom;
            in_npc    = $urandom;
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b0;

`ifdef IFID_PERF_EN
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h1234_5678;
        step();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            seen = w_valid[1];
        end
        chk("perf_wait_valid", 64'(seen), 64'd1);
        repeat (7) step();
        flush     = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        flush = 1'b0;
        step();
        chk("perf_stall_7", 64'(w_stall[1]), 64'd7);
        chk("perf_flush_3", 64'(w_flush[1]), 64'd3);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (4) step();
        in_valid = 1'b0;
        repeat (70000) step();
        chk("perf_stall_sat", 64'(w_stall[1]), 64'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
